alu_exec: RTL
=============

# alu_exec

Single-cycle integer execution unit that receives arithmetic, compare and JALR operations issued by the reservation station and returns results on the ALU result broadcast bus. That bus feeds the reservation station, the load/store buffer and the ROB. The result is registered, so each accepted issue appears on the broadcast bus exactly one cycle later. Pending results are squashed on a branch mispredict flush.

## Interface

Parameters:
- `XLEN`, 32, operand and result width.
- `ROBW`, 4, ROB index width; must match the ROB and RS index width.
- `OPW`, 6, width of the internal instruction code; codes are the shared `defines.v` names (`ADD`, `SUB`, `BEQ`, `JALR`, ...).

Ports:
- `clk`, input, 1, sole clock; all state updates on rising edge.
- `rst`, input, 1, asynchronous, active-low reset.
- `rdy`, input, 1, global ready; when low, all state holds and issue is ignored.
- `jp_wrong`, input, 1, mispredict flush from the ROB.
- `ari_ins_flag`, input, 1, issue valid from the RS; there is no backpressure.
- `ari_insty`, input, OPW, operation code.
- `ari_val1`, input, XLEN, operand 1 (rs1 value).
- `ari_val2`, input, XLEN, operand 2 (rs2 value, or the immediate already substituted by the RS).
- `ari_ROB_idx`, input, ROBW, destination ROB entry.
- `val_flag_RS`, output, 1, broadcast valid.
- `val_idx_RS`, output, ROBW, broadcast ROB index.
- `val_RS`, output, XLEN, broadcast value.

## Operation

Issue acceptance:
- An issue is accepted on a rising edge when `rst`=1, `rdy`=1, `jp_wrong`=0 and `ari_ins_flag`=1.
- Accepted ops load the result register: `val_flag_RS`<=1, `val_idx_RS`<=`ari_ROB_idx`, `val_RS`<=f(op).
- On a non-accepting edge with `rdy`=1, `val_flag_RS`<=0. Index and value hold their old contents (don't-care).

Arithmetic (all XLEN-bit, wrap-around; overflow ignored):
- ADD/ADDI: a+b. SUB: a−b. AND/ANDI, OR/ORI, XOR/XORI: bitwise.
- SLL/SLLI, SRL/SRLI: logical shift; shift amount b[4:0], upper bits of b ignored.
- SRA/SRAI: arithmetic shift, sign-filling from a[31].
- SLT/SLTI: signed a<b gives 1, else 0. SLTU/SLTIU: unsigned compare, same encoding.
- LUI: result = b (the RS places imm in val2).

Branches (result is the resolved outcome: 1 = taken, 0 = not taken, zero-extended):
- BEQ: a==b. BNE: a!=b.
- BLT, BGE: signed compare.
- BLTU, BGEU: unsigned compare.

JALR:
- Result is the target (a+b) with bit 0 cleared.
- The link value is produced by the ROB, not by this unit.

Unknown or unlisted code: result 0. Still broadcast with `val_flag_RS`=1 so the ROB entry does not deadlock.

## Timing

- Latency is 1 cycle: issue at edge N gives a broadcast visible during cycle N+1 to N+2.
- Throughput is one op per cycle; back-to-back issues give back-to-back broadcasts.
- Reset: when `rst` falls, immediately and asynchronously `val_flag_RS`=0, `val_idx_RS`=0, `val_RS`=0. Stays there while `rst`=0. First accepted issue is on the first edge with `rst`=1.
- Reset mid-operation: an in-flight result is lost; no broadcast after reset is released.
- `jp_wrong`=1 at an edge (with `rdy`=1): `val_flag_RS`<=0, and any simultaneous issue is dropped. A result already on the bus during the `jp_wrong` cycle is not retracted; consumers discard it via their own flush.
- `rdy`=0: outputs hold exactly, including `val_flag_RS`=1 if set, and the issue is not accepted.
  - The RS does not free its entry when `rdy`=0, so it re-issues the op later.
- Outputs are driven only from registers; there is no combinational path from any input to any output.

## Test plan

- Issue ADD with a=5, b=7, idx=3 at edge N → during cycle N+1: `val_flag_RS`=1, `val_idx_RS`=3, `val_RS`=12. Next cycle with no issue: flag=0.
- Back-to-back: SRA a=0x80000000, b=0x24 (shift 4), idx=1; then SLTU a=1, b=0xFFFFFFFF, idx=2 → broadcasts 0xF8000000@1 then 1@2 on consecutive cycles.
- Branches and JALR:
  - BLT a=0xFFFFFFFF, b=0 → 1.
  - BLTU with the same operands → 0.
  - JALR a=0x1001, b=0x10 → 0x1010.
- Flush: issue at the same edge as `jp_wrong`=1 → flag stays 0. An issue on the following edge broadcasts normally.
- `rdy` held 0 for 3 cycles with flag=1, idx=5 → outputs unchanged throughout; issues during the stall produce nothing.
- Assert `rst`=0 asynchronously between edges while flag=1 → all outputs 0 before the next edge. Release reset, then issue XOR 0xF0F0^0xFF00 → 0x0FF0.

Source files
------------

// File: rtl/alu_exec.sv
// alu_exec: single-cycle integer execution unit. Computes arithmetic, compare,
// branch-outcome and JALR-target results and broadcasts them, registered, one
// cycle after issue. Pending results are squashed on a mispredict flush.
module alu_exec #(
  parameter int XLEN = 32,
  parameter int ROBW = 4,
  parameter int OPW  = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rdy,
  input  logic            jp_wrong,
  input  logic            ari_ins_flag,
  input  logic [OPW-1:0]  ari_insty,
  input  logic [XLEN-1:0] ari_val1,
  input  logic [XLEN-1:0] ari_val2,
  input  logic [ROBW-1:0] ari_ROB_idx,
  output logic            val_flag_RS,
  output logic [ROBW-1:0] val_idx_RS,
  output logic [XLEN-1:0] val_RS
);

  // Shared instruction codes (same numbering as the rest of the core).
  localparam logic [OPW-1:0] OP_LUI   = OPW'(1);
  localparam logic [OPW-1:0] OP_JALR  = OPW'(4);
  localparam logic [OPW-1:0] OP_BEQ   = OPW'(5);
  localparam logic [OPW-1:0] OP_BNE   = OPW'(6);
  localparam logic [OPW-1:0] OP_BLT   = OPW'(7);
  localparam logic [OPW-1:0] OP_BGE   = OPW'(8);
  localparam logic [OPW-1:0] OP_BLTU  = OPW'(9);
  localparam logic [OPW-1:0] OP_BGEU  = OPW'(10);
  localparam logic [OPW-1:0] OP_ADDI  = OPW'(19);
  localparam logic [OPW-1:0] OP_SLTI  = OPW'(20);
  localparam logic [OPW-1:0] OP_SLTIU = OPW'(21);
  localparam logic [OPW-1:0] OP_XORI  = OPW'(22);
  localparam logic [OPW-1:0] OP_ORI   = OPW'(23);
  localparam logic [OPW-1:0] OP_ANDI  = OPW'(24);
  localparam logic [OPW-1:0] OP_SLLI  = OPW'(25);
  localparam logic [OPW-1:0] OP_SRLI  = OPW'(26);
  localparam logic [OPW-1:0] OP_SRAI  = OPW'(27);
  localparam logic [OPW-1:0] OP_ADD   = OPW'(28);
  localparam logic [OPW-1:0] OP_SUB   = OPW'(29);
  localparam logic [OPW-1:0] OP_SLL   = OPW'(30);
  localparam logic [OPW-1:0] OP_SLT   = OPW'(31);
  localparam logic [OPW-1:0] OP_SLTU  = OPW'(32);
  localparam logic [OPW-1:0] OP_XOR   = OPW'(33);
  localparam logic [OPW-1:0] OP_SRL   = OPW'(34);
  localparam logic [OPW-1:0] OP_SRA   = OPW'(35);
  localparam logic [OPW-1:0] OP_OR    = OPW'(36);
  localparam logic [OPW-1:0] OP_AND   = OPW'(37);

  logic            flag_q;
  logic [ROBW-1:0] idx_q;
  logic [XLEN-1:0] val_q;
  logic [XLEN-1:0] result_d;
  logic            accept_d;

  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [4:0]      shamt;
  logic            lt_s;
  logic            lt_u;
  logic            eq;
  logic [XLEN-1:0] sum;

  assign a     = ari_val1;
  assign b     = ari_val2;
  assign shamt = ari_val2[4:0];   // upper bits of the shift operand are ignored
  assign lt_s  = $signed(a) < $signed(b);
  assign lt_u  = a < b;
  assign eq    = (a == b);
  assign sum   = a + b;

  // An issue only counts when the unit is ready and no flush is in progress.
  assign accept_d = ari_ins_flag && !jp_wrong;

  // Result mux: compute f(op) for the current issue; unknown codes yield 0.
  always_comb begin
    result_d = '0;
    case (ari_insty)
      OP_ADD, OP_ADDI:   result_d = sum;
      OP_SUB:            result_d = a - b;
      OP_AND, OP_ANDI:   result_d = a & b;
      OP_OR,  OP_ORI:    result_d = a | b;
      OP_XOR, OP_XORI:   result_d = a ^ b;
      OP_SLL, OP_SLLI:   result_d = a << shamt;
      OP_SRL, OP_SRLI:   result_d = a >> shamt;
      OP_SRA, OP_SRAI:   result_d = $unsigned($signed(a) >>> shamt);
      OP_SLT, OP_SLTI:   result_d = {{(XLEN-1){1'b0}}, lt_s};
      OP_SLTU, OP_SLTIU: result_d = {{(XLEN-1){1'b0}}, lt_u};
      OP_LUI:            result_d = b;
      OP_BEQ:            result_d = {{(XLEN-1){1'b0}}, eq};
      OP_BNE:            result_d = {{(XLEN-1){1'b0}}, !eq};
      OP_BLT:            result_d = {{(XLEN-1){1'b0}}, lt_s};
      OP_BGE:            result_d = {{(XLEN-1){1'b0}}, !lt_s};
      OP_BLTU:           result_d = {{(XLEN-1){1'b0}}, lt_u};
      OP_BGEU:           result_d = {{(XLEN-1){1'b0}}, !lt_u};
      // Jump target with bit 0 cleared; the link value comes from the ROB.
      OP_JALR:           result_d = {sum[XLEN-1:1], 1'b0};
      default:           result_d = '0;
    endcase
  end

  // Broadcast register: load on accepted issue, drop valid otherwise, freeze on !rdy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flag_q <= 1'b0;
      idx_q  <= '0;
      val_q  <= '0;
    end else if (rdy) begin
      if (accept_d) begin
        flag_q <= 1'b1;
        idx_q  <= ari_ROB_idx;
        val_q  <= result_d;
      end else begin
        flag_q <= 1'b0;
      end
    end
  end

  assign val_flag_RS = flag_q;
  assign val_idx_RS  = idx_q;
  assign val_RS      = val_q;

endmodule
